// File: rtl/osiris_wb_pkg.sv
// osiris_wb_pkg: shared types, widths and defaults for the Wishbone classic master
package osiris_wb_pkg;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int SEL_W       = 4;
   localparam int CNT_W       = 16;
   localparam int TIMEOUT_DEF = 256;
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction
endpackage

// File: rtl/osiris_wb_timeout.sv
// osiris_wb_timeout: counts stalled BUS cycles and flags when the slave must be abandoned
module osiris_wb_timeout import osiris_wb_pkg::*; #(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst || clear) cnt <= '0;
      else if (enable) cnt <= cnt + CNT_W'(1);
   end
   assign expired = cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/osiris_wb_master.sv
// osiris_wb_master: single-outstanding core-request to Wishbone classic bridge with timeout
module osiris_wb_master import osiris_wb_pkg::*; #(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic [SEL_W-1:0]  req_sel_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic [SEL_W-1:0]  wb_sel_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);
   state_e state, state_n;
   logic hs, term, fail, expired;
   logic ready_d, cyc_d, rsp_valid_d, err_d, we_d;
   logic [DATA_W-1:0] rdata_d, dat_d;
   logic [ADDR_W-1:0] adr_d;
   logic [SEL_W-1:0] sel_d;
   assign hs = state == IDLE && req_valid_i && req_ready_o;
   assign term = state == BUS && (wb_ack_i || wb_err_i || expired);
   // err beats ack; a timeout without ack is reported exactly like a slave error
   assign fail = wb_err_i || !wb_ack_i;
   osiris_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .clear(state != BUS),
      .enable(state == BUS && !wb_ack_i && !wb_err_i),
      .expired(expired)
   );
   always_ff @(posedge wb_clk_i) begin
      state <= wb_rst_i ? IDLE : state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = hs ? BUS : IDLE;
         BUS:     state_n = term ? RESP : BUS;
         RESP:    state_n = rsp_ready_i ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      ready_d     = state_n == IDLE;
      cyc_d       = state_n == BUS;
      rsp_valid_d = state_n == RESP;
      err_d       = term ? fail : rsp_err_o;
      rdata_d     = term ? ((fail || wb_we_o) ? '0 : wb_dat_i) : rsp_rdata_o;
      we_d        = hs ? req_we_i : wb_we_o;
      adr_d       = hs ? word_addr(req_addr_i) : wb_adr_o;
      dat_d       = hs ? (req_we_i ? req_wdata_i : '0) : wb_dat_o;
      sel_d       = hs ? req_sel_i : wb_sel_o;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         req_ready_o <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         wb_sel_o    <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         req_ready_o <= ready_d;
         wb_cyc_o    <= cyc_d;
         wb_stb_o    <= cyc_d;
         wb_we_o     <= we_d;
         wb_adr_o    <= adr_d;
         wb_dat_o    <= dat_d;
         wb_sel_o    <= sel_d;
         rsp_valid_o <= rsp_valid_d;
         rsp_err_o   <= err_d;
         rsp_rdata_o <= rdata_d;
      end
   end
endmodule

// File: tb/tb_osiris_wb_master.sv
// tb_osiris_wb_master: directed stimulus checked every cycle against a transaction-level model
module tb_osiris_wb_master;
   localparam int TO = 8;
   logic clk = 0, rst = 1;
   logic req_valid = 0, req_we = 0, rsp_ready = 0, ack = 0, err = 0;
   logic [31:0] req_addr = 0, req_wdata = 0, dat_i = 0;
   logic [3:0] req_sel = 0;
   logic req_ready_o, rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] rsp_rdata_o, wb_adr_o, wb_dat_o;
   logic [3:0] wb_sel_o;
   logic e_ready = 0, e_cyc = 0, e_we = 0, e_rv = 0, e_err = 0;
   logic [31:0] e_adr = 0, e_dat = 0, e_rdata = 0;
   logic [3:0] e_sel = 0;
   int bus_n = 0, n_chk = 0, n_fail = 0, n;
   bit started = 0;

   osiris_wb_master #(.TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a transfer lives on the bus until ack, err or TO cycles elapse
   always @(posedge clk) begin
      started = 1;
      if (rst) begin
         e_ready = 0; e_cyc = 0; e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0;
         e_rv = 0; e_rdata = 0; e_err = 0;
      end else if (e_rv) begin
         if (rsp_ready) begin e_rv = 0; e_ready = 1; end
      end else if (e_cyc) begin
         bus_n++;
         if (ack || err || bus_n == TO) begin
            e_cyc = 0;
            e_rv = 1;
            e_err = err || !ack;
            e_rdata = (e_err || e_we) ? 32'h0 : dat_i;
         end
      end else if (e_ready) begin
         if (req_valid) begin
            e_ready = 0; e_cyc = 1; e_we = req_we; bus_n = 0;
            e_adr = {req_addr[31:2], 2'b00};
            e_dat = req_we ? req_wdata : 32'h0;
            e_sel = req_sel;
         end
      end else e_ready = 1;
   end

   always @(negedge clk) if (started) begin
      chk("req_ready", req_ready_o, e_ready);
      chk("cyc", wb_cyc_o, e_cyc);
      chk("stb", wb_stb_o, e_cyc);
      chk("we", wb_we_o, e_we);
      chk("adr", wb_adr_o, e_adr);
      chk("dat", wb_dat_o, e_dat);
      chk("sel", wb_sel_o, e_sel);
      chk("rsp_valid", rsp_valid_o, e_rv);
      chk("rsp_rdata", rsp_rdata_o, e_rdata);
      chk("rsp_err", rsp_err_o, e_err);
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int i = 0;
      while (!req_ready_o && i < 50) begin step(1); i++; end
      chk("req_accept_wait", req_ready_o, 1);
      req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_sel = s;
      step(1);
      req_valid = 0;
   endtask

   task automatic take_rsp();
      rsp_ready = 1; step(1); rsp_ready = 0;
   endtask

   initial begin
      step(3);
      chk("rst_ready", req_ready_o, 0);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_rv", rsp_valid_o, 0);
      rst = 0;
      step(1);
      chk("ready_after_rst", req_ready_o, 1);

      do_req(0, 32'h3000_0004, 32'h5555_5555, 4'hF);
      chk("rd_cyc_next", wb_cyc_o, 1);
      chk("rd_adr", wb_adr_o, 32'h3000_0004);
      chk("rd_dat_zero", wb_dat_o, 0);
      step(2); ack = 1; dat_i = 32'hDEAD_BEEF;
      step(1); ack = 0; dat_i = 0;
      chk("rd_rv_after_ack", rsp_valid_o, 1);
      chk("rd_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
      chk("rd_err", rsp_err_o, 0);
      chk("rd_cyc_drop", wb_cyc_o, 0);
      take_rsp();
      chk("rd_rv_clear", rsp_valid_o, 0);
      chk("rd_ready_back", req_ready_o, 1);

      do_req(1, 32'h3000_0013, 32'h1234_5678, 4'b0011);
      chk("wr_adr", wb_adr_o, 32'h3000_0010);
      chk("wr_dat", wb_dat_o, 32'h1234_5678);
      chk("wr_sel", wb_sel_o, 4'b0011);
      ack = 1; dat_i = 32'hA5A5_A5A5;
      step(1); ack = 0; dat_i = 0;
      chk("wr_rv", rsp_valid_o, 1);
      chk("wr_rdata_zero", rsp_rdata_o, 0);
      chk("wr_err", rsp_err_o, 0);
      take_rsp();

      do_req(0, 32'h3000_0100, 0, 4'hF);
      ack = 1; err = 1; dat_i = 32'hFFFF_FFFF;
      step(1); ack = 0; err = 0; dat_i = 0;
      chk("err_flag", rsp_err_o, 1);
      chk("err_rdata", rsp_rdata_o, 0);
      take_rsp();

      do_req(0, 32'h3000_0200, 0, 4'hF);
      n = 0;
      while (wb_cyc_o && n < 40) begin n++; step(1); end
      chk("to_bus_cycles", n, 8);
      chk("to_err", rsp_err_o, 1);
      chk("to_rv", rsp_valid_o, 1);
      ack = 1; dat_i = 32'h1111_1111;
      step(2); ack = 0; dat_i = 0;
      chk("to_late_ack_rdata", rsp_rdata_o, 0);
      chk("to_late_ack_err", rsp_err_o, 1);
      take_rsp();
      ack = 1; step(1); ack = 0;
      chk("idle_ack_cyc", wb_cyc_o, 0);
      chk("idle_ack_rv", rsp_valid_o, 0);

      do_req(0, 32'h3000_0300, 0, 4'hF);
      ack = 1; dat_i = 32'h7654_3210;
      step(1); ack = 0; dat_i = 0;
      req_valid = 1; req_we = 0; req_addr = 32'h3000_0404; req_sel = 4'hF;
      step(5);
      chk("bp_rv_held", rsp_valid_o, 1);
      chk("bp_rdata_held", rsp_rdata_o, 32'h7654_3210);
      chk("bp_ready_low", req_ready_o, 0);
      chk("bp_no_cyc", wb_cyc_o, 0);
      take_rsp();
      chk("b2b_ready", req_ready_o, 1);
      step(1); req_valid = 0;
      chk("b2b_cyc", wb_cyc_o, 1);
      chk("b2b_adr", wb_adr_o, 32'h3000_0404);
      ack = 1; dat_i = 32'h0BAD_F00D;
      step(1); ack = 0; dat_i = 0;
      chk("b2b_rdata", rsp_rdata_o, 32'h0BAD_F00D);
      take_rsp();

      do_req(0, 32'h3000_0500, 0, 4'hF);
      step(2);
      rst = 1; req_valid = 1; req_addr = 32'h3000_0600;
      step(1); rst = 0; req_valid = 0;
      chk("mid_rst_cyc", wb_cyc_o, 0);
      chk("mid_rst_stb", wb_stb_o, 0);
      chk("mid_rst_rv", rsp_valid_o, 0);
      step(3);
      chk("mid_rst_no_rsp", rsp_valid_o, 0);
      do_req(0, 32'h3000_0704, 0, 4'hF);
      step(1); ack = 1; dat_i = 32'hCAFE_F00D;
      step(1); ack = 0; dat_i = 0;
      chk("fresh_rv", rsp_valid_o, 1);
      chk("fresh_rdata", rsp_rdata_o, 32'hCAFE_F00D);
      take_rsp();
      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/osiris_wb_master.md
OSIRIS_WB_MASTER -- requirements
Module: osiris_wb_master

Interface
REQ-001 Parameter TIMEOUT, 256, number of cycles in BUS without ack/err before forced termination (2..65535).
REQ-002 wb_clk_i  in  1  single clock; all logic is rising-edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 req_valid_i  in  1  core request valid.
REQ-005 req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
REQ-006 req_we_i  in  1  1 = write, 0 = read.
REQ-007 req_addr_i  in  32  byte address.
REQ-008 req_wdata_i  in  32  write data.
REQ-009 req_sel_i  in  4  byte-lane enables.
REQ-010 rsp_valid_o  out  1  response valid; held until rsp_ready_i.
REQ-011 rsp_ready_i  in  1  core accepts response.
REQ-012 rsp_rdata_o  out  32  read data; 0 for writes and errors.
REQ-013 rsp_err_o  out  1  1 = bus error or timeout.
REQ-014 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls.
REQ-015 wb_adr_o  out  32  Wishbone address; wb_dat_o  out  32; wb_sel_o  out  4.
REQ-016 wb_dat_i  in  32; wb_ack_i  in  1; wb_err_i  in  1  slave response.

Function
REQ-017 States IDLE, BUS, RESP; one transaction outstanding at a time; all outputs registered.
REQ-018 IDLE: req_ready_o=1; on handshake latch we/addr/wdata/sel, go BUS; wb_cyc_o=wb_stb_o=1 from the next cycle.
REQ-019 wb_adr_o = latched addr with bits [1:0] forced 0; wb_dat_o = latched wdata on writes, 0 on reads; all held stable throughout BUS.
REQ-020 BUS: req_ready_o=0; on wb_ack_i capture wb_dat_i (reads only), rsp_err_o=0, go RESP.
REQ-021 BUS: on wb_err_i rsp_err_o=1, rsp_rdata_o=0, go RESP; ack and err same cycle -> err wins.
REQ-022 Timeout counter clears on BUS entry, increments each BUS cycle without ack/err; at count TIMEOUT-1 terminate as error (REQ-021 response).
REQ-023 wb_cyc_o/wb_stb_o deassert on the edge after termination (ack, err or timeout); rsp_valid_o asserts same edge.
REQ-024 RESP: rsp_valid_o=1, req_ready_o=0; when rsp_ready_i=1 go IDLE, rsp_valid_o=0 next cycle.
REQ-025 Latency: handshake cycle N -> cyc at N+1; ack cycle M -> rsp_valid at M+1; next request acceptable at M+2 at earliest.
REQ-026 wb_ack_i/wb_err_i outside BUS are ignored; no state or output change.
REQ-027 Inputs on req_* while req_ready_o=0 are ignored.

Reset
REQ-028 wb_rst_i=1 at an edge: state=IDLE, counter=0, req_ready_o=0 during reset then 1 after, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/wb_dat_o/rsp_rdata_o=0, wb_sel_o=0, rsp_valid_o=rsp_err_o=0.
REQ-029 Reset mid-BUS drops cyc/stb on that edge and produces no response; reset wins over any same-cycle handshake.

Structure
REQ-030 Package osiris_wb_pkg holds state enum (IDLE/BUS/RESP), address/data/sel width constants and default TIMEOUT.
REQ-031 Timeout counter is sub-module osiris_wb_timeout (clear, enable, expired output, TIMEOUT parameter); everything else in osiris_wb_master.

Verification
REQ-032 Read: req addr 0x3000_0004, we=0; slave acks 2 cycles after stb with 0xDEADBEEF -> wb_adr_o=0x3000_0004, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid at ack+1.
REQ-033 Write: addr 0x3000_0013, wdata 0x1234_5678, sel 4'b0011, zero-wait ack -> wb_adr_o=0x3000_0010, wb_dat_o=0x1234_5678, wb_sel_o=0011, rsp_rdata_o=0, rsp_err_o=0.
REQ-034 Error: wb_ack_i and wb_err_i both high on first BUS cycle with dat_i=0xFFFF_FFFF -> rsp_err_o=1, rsp_rdata_o=0.
REQ-035 Timeout: TIMEOUT=8, slave never responds -> cyc drops after exactly 8 BUS cycles, rsp_err_o=1; stray late ack then ignored.
REQ-036 Backpressure/back-to-back: hold rsp_ready_i=0 5 cycles -> rsp_valid and data stable, req_ready_o=0; second request accepted cycle after rsp_ready_i=1.
REQ-037 Reset mid-BUS -> cyc/stb=0 next edge, no rsp_valid_o, fresh read afterwards completes normally.
